fifo_drain_packer: RTL and testbench
====================================

Name: fifo_drain_packer

Overview:
- Downstream consumer of the 32-bit synchronous FIFO (fifo_sync).
- Pops words through the FIFO's cs/rd_en/empty interface, which has 1-cycle read latency.
- Packs PACK consecutive words into one wide beat and presents it on a valid/ready stream to the next stage.
- A flush input forces a partial beat out at end of packet.

Parameters:
- DATA_WIDTH, 32: FIFO word width.
- PACK, 2: words per output beat (>=2).
- PACK_LOG, 1: clog2(PACK); the word counter is PACK_LOG+1 bits wide.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO data_out; valid the cycle after a read.
- fifo_cs  out  1  FIFO chip select; always equal to fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop request (combinational).
- flush  in  1  single-cycle pulse: emit the partial beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH*PACK  packed beat; word 0 in bits [DATA_WIDTH-1:0].
- out_count  out  PACK_LOG+1  number of valid words in the beat (1..PACK).
- busy  out  1  high when state==OUT, or word count != 0, or rd_pend.

Behaviour:
- Reset (async, rst=1):
  - state=FILL; word count, rd_pend and flush_pend = 0.
  - out_valid=0, out_data=0, out_count=0, busy=0.
  - fifo_rd_en=0 while rst is high.
- Interface with fifo_sync:
  - fifo_rd_en = (state==FILL) && !fifo_empty && !flush_pend && (cnt + rd_pend < PACK).
  - rd_pend register <= fifo_rd_en each cycle.
  - When rd_pend=1, fifo_data is captured into lane cnt and cnt increments.
  - At most PACK reads are outstanding or held at any time.
- FSM, two states:
  - FILL: issue reads as above. Move to OUT at the edge where cnt reaches PACK; out_valid goes high the following cycle.
  - OUT: out_valid=1; out_data and out_count are stable and no FIFO reads are issued. On out_valid && out_ready: cnt=0, unused lanes cleared to 0, return to FILL.
- Throughput: with PACK=2, FIFO non-empty and out_ready=1, one beat every 4 cycles (reads issued in cycles 0 and 1, out_valid in cycle 3).
- Flush:
  - A flush pulse sets flush_pend; new reads stop.
  - Once rd_pend=0: if cnt>0, go to OUT with out_count=cnt and unfilled lanes 0; if cnt==0, clear flush_pend and stay in FILL (no beat).
  - flush_pend clears when the partial beat is accepted.
  - flush in OUT state is latched and applied on return to FILL.
- Boundaries:
  - fifo_empty high mid-fill: wait indefinitely holding the partial words (no timeout).
  - out_ready held low: beat held, no FIFO pops, so the FIFO may fill.
  - Simultaneous flush and last capture completing a full beat: a normal full beat is sent; flush_pend then resolves with cnt==0 (no extra beat).
- Reset mid-operation: all state cleared immediately. A read in flight is lost, so the FIFO must share the same reset.
- Widths: cnt is PACK_LOG+1 bits; no wrap, since it saturates at PACK by construction.

Optional Feature:
- Macro: DRAIN_CNT_EN.
- Defined: adds output port beat_cnt [15:0].
  - Increments on every accepted beat (out_valid && out_ready), partial beats included.
  - Wraps 0xFFFF -> 0; reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-fill after one word captured -> all outputs 0 immediately, fifo_rd_en=0; after release, next beat starts from lane 0.
- Basic pack: FIFO holds 1,10,100,1000, out_ready=1 -> beats 64'h0000000A_00000001 and 64'h000003E8_00000064, out_count=2 each, exactly 4 pops.
- Backpressure: FIFO holds 8 words 2**i, out_ready=0 for 20 cycles -> first beat held stable, fifo_rd_en=0 throughout; then 4 beats in order {2,1},{8,4},{32,16},{128,64}.
- Flush partial: write only 7 then pulse flush -> beat out_data=64'h00000000_00000007, out_count=1; flush with cnt==0 -> no beat, busy returns to 0.
- Empty stall: write 5, wait 10 cycles, write 6 -> single beat {6,5} after the second write; out_valid stays low while waiting.
- DRAIN_CNT_EN: send 3 beats, 1 of them partial -> beat_cnt=3; preload near wrap via 65536 beats -> beat_cnt wraps to 0.

Source files
------------

// File: rtl/fifo_drain_packer.sv
// rtl/fifo_drain_packer.sv - packs PACK FIFO words into one wide valid/ready beat; DRAIN_CNT_EN adds beat_cnt
module fifo_drain_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK       = 2,
    parameter int PACK_LOG   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_data,
    output logic                       fifo_cs,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK_LOG:0]          out_count,
`ifdef DRAIN_CNT_EN
    output logic [15:0]                beat_cnt,
`endif
    output logic                       busy
);

    localparam int CNT_W = PACK_LOG + 1;
    localparam logic [CNT_W:0]   PACK_EXT = (CNT_W + 1)'(PACK);
    localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);
    localparam logic [CNT_W-1:0] PACK_M1  = CNT_W'(PACK - 1);

    typedef enum logic {S_FILL = 1'b0, S_OUT = 1'b1} state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_rd_pend;
    logic                        r_flush_pend;
    logic [DATA_WIDTH*PACK-1:0]  r_data;
    logic [CNT_W:0]              w_inflight;
    logic                        w_rd_en;
    logic                        w_accept;
    logic                        w_last_capture;
    logic                        w_flush_go;
    logic                        w_flush_clr;

    // Words already held plus the one in flight must never exceed a beat.
    assign w_inflight     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_rd_pend};
    assign w_rd_en        = !rst && (r_state == S_FILL) && !fifo_empty && !r_flush_pend
                            && (w_inflight < PACK_EXT);
    assign w_accept       = (r_state == S_OUT) && out_ready;
    assign w_last_capture = (r_state == S_FILL) && r_rd_pend && (r_cnt == PACK_M1);
    assign w_flush_go     = (r_state == S_FILL) && r_flush_pend && !r_rd_pend;
    // A full beat leaves flush_pend set so it resolves in FILL with an empty count.
    assign w_flush_clr    = (w_accept && (r_cnt != PACK_CNT)) || (w_flush_go && (r_cnt == '0));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: leave FILL on the last capture or a resolved flush, leave OUT on accept
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL: begin
                if (w_last_capture) begin
                    w_state_next = S_OUT;
                end else if (w_flush_go && (r_cnt != '0)) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_next = S_FILL;
                end
            end
            default: w_state_next = S_FILL;
        endcase
    end

    // Outputs decoded from state and the held beat
    always_comb begin
        fifo_rd_en = w_rd_en;
        fifo_cs    = w_rd_en;
        out_valid  = (r_state == S_OUT);
        out_count  = (r_state == S_OUT) ? r_cnt : '0;
        out_data   = r_data;
        busy       = (r_state == S_OUT) || (r_cnt != '0) || r_rd_pend;
    end

    // Datapath: track the in-flight read, capture into lane cnt, clear lanes on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_cnt        <= '0;
            r_data       <= '0;
        end else begin
            r_rd_pend    <= w_rd_en;
            r_flush_pend <= flush || (r_flush_pend && !w_flush_clr);
            if (w_accept) begin
                r_cnt  <= '0;
                r_data <= '0;
            end else if (r_rd_pend) begin
                for (int i = 0; i < PACK; i++) begin
                    if (r_cnt == CNT_W'(i)) begin
                        r_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                    end
                end
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DRAIN_CNT_EN
    logic [15:0] r_beat_cnt;

    // Count every accepted beat, partial or full; wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_drain_packer.sv
// tb/tb_fifo_drain_packer.sv - scoreboard bench for fifo_drain_packer with a FIFO model and packing reference
module tb_fifo_drain_packer;

    localparam int DW = 32;
    localparam int PK = 2;
    localparam int PL = 1;

    typedef struct {
        logic [DW*PK-1:0] data;
        logic [PL:0]      count;
    } beat_t;

    logic              clk;
    logic              rst;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_data;
    logic              fifo_cs;
    logic              fifo_rd_en;
    logic              flush;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW*PK-1:0]  out_data;
    logic [PL:0]       out_count;
    logic              busy;
`ifdef DRAIN_CNT_EN
    logic [15:0]       beat_cnt;
`endif

    fifo_drain_packer #(.DATA_WIDTH(DW), .PACK(PK), .PACK_LOG(PL)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_cs    (fifo_cs),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
`ifdef DRAIN_CNT_EN
        .beat_cnt   (beat_cnt),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int n_exp_total = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend_q[$];
    beat_t         exp_q[$];
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          force_rdy;
    logic          rdy_val;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: words are grouped in arrival order; a flush emits whatever is left.
    function automatic void model_emit();
        beat_t b;
        b.data = '0;
        for (int i = 0; i < pend_q.size(); i++) b.data[i*DW +: DW] = pend_q[i];
        b.count = (PL + 1)'(pend_q.size());
        exp_q.push_back(b);
        pend_q.delete();
        n_exp_total++;
    endfunction

    function automatic void model_word(input logic [DW-1:0] w);
        pend_q.push_back(w);
        if (pend_q.size() == PK) model_emit();
    endfunction

    function automatic void model_flush();
        if (pend_q.size() > 0) model_emit();
    endfunction

    // Synchronous FIFO model with one-cycle read latency, sharing the DUT reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_data  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() > 0) begin
                fifo_data <= fq.pop_front();
                pops++;
            end
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    beat_t            mon_b;
    logic             hold_v = 1'b0;
    logic [DW*PK-1:0] hold_d;
    logic [PL:0]      hold_c;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            chk(fifo_cs == fifo_rd_en, "cs_eq_rd_en", 64'(fifo_cs), 64'(fifo_rd_en));
            if (fifo_rd_en) chk(!fifo_empty, "pop_when_empty", 64'(fifo_empty), 64'd0);
            if (out_valid) begin
                chk(!fifo_rd_en, "pop_during_out", 64'(fifo_rd_en), 64'd0);
                if (hold_v) begin
                    chk(out_data == hold_d, "hold_data", out_data, hold_d);
                    chk(out_count == hold_c, "hold_count", 64'(out_count), 64'(hold_c));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", out_data, 64'd0);
                    end else begin
                        mon_b = exp_q.pop_front();
                        chk(out_data == mon_b.data, "beat_data", out_data, mon_b.data);
                        chk(out_count == mon_b.count, "beat_count", 64'(out_count), 64'(mon_b.count));
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hold_d = out_data;
                    hold_c = out_count;
                end
            end else begin
                if (hold_v) chk(1'b0, "valid_dropped", 64'd0, 64'd1);
                hold_v = 1'b0;
            end
        end
    end

    task automatic write_word(input logic [DW-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        model_word(w);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_empty();
        int i;
        for (i = 0; i < 400; i++) begin
            if (fifo_empty && fq.size() == 0) break;
            @(negedge clk);
        end
        if (i == 400) chk(1'b0, "empty_timeout", 64'(fq.size()), 64'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        model_flush();
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && fifo_empty) break;
            @(negedge clk);
        end
        if (i == 400) chk(1'b0, "idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(out_valid == 1'b0, {tag, "_valid"}, 64'(out_valid), 64'd0);
        chk(out_data == '0, {tag, "_data"}, out_data, 64'd0);
        chk(out_count == '0, {tag, "_count"}, 64'(out_count), 64'd0);
        chk(busy == 1'b0, {tag, "_busy"}, 64'(busy), 64'd0);
        chk(fifo_rd_en == 1'b0, {tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
    endtask

    initial begin
        int pops0;
        int n;
        wr_en = 1'b0;
        wr_data = '0;
        flush = 1'b0;
        force_rdy = 1'b1;
        rdy_val = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Reset mid-fill after one word captured
        write_word(32'd42);
        repeat (4) @(negedge clk);
        chk(busy == 1'b1, "busy_mid_fill", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        pend_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Basic pack: 1,10,100,1000 -> two full beats, exactly four pops
        pops0 = pops;
        write_word(32'd1);
        write_word(32'd10);
        write_word(32'd100);
        write_word(32'd1000);
        wait_idle();
        repeat (4) @(negedge clk);
        chk(pops - pops0 == 4, "basic_pops", 64'(pops - pops0), 64'd4);

        // Backpressure: first beat held while the FIFO backs up
        rdy_val = 1'b0;
        for (int i = 0; i < 8; i++) write_word(32'(1) << i);
        repeat (20) @(negedge clk);
        chk(out_valid == 1'b1, "bp_valid_held", 64'(out_valid), 64'd1);
        chk(fq.size() == 6, "bp_fifo_level", 64'(fq.size()), 64'd6);
        rdy_val = 1'b1;
        wait_idle();

        // Flush a single word, then a flush with nothing held
        write_word(32'd7);
        wait_empty();
        do_flush();
        wait_idle();
        repeat (3) @(negedge clk);
        do_flush();
        repeat (6) @(negedge clk);
        chk(busy == 1'b0, "flush_empty_busy", 64'(busy), 64'd0);
        chk(exp_q.size() == 0, "flush_empty_nobeat", 64'(exp_q.size()), 64'd0);

        // Empty stall mid-fill
        write_word(32'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk(out_valid == 1'b0, "stall_no_valid", 64'(out_valid), 64'd0);
        end
        write_word(32'd6);
        wait_idle();

        // Randomized traffic, random backpressure and flushes
        force_rdy = 1'b0;
        for (int it = 0; it < 60; it++) begin
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) begin
                write_word($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            if ($urandom_range(0, 2) == 0) begin
                wait_empty();
                do_flush();
            end
        end

        force_rdy = 1'b1;
        rdy_val = 1'b1;
        wait_empty();
        do_flush();
        wait_idle();
        repeat (6) @(negedge clk);
        chk(exp_q.size() == 0, "all_beats_drained", 64'(exp_q.size()), 64'd0);
        chk(busy == 1'b0, "final_busy", 64'(busy), 64'd0);
`ifdef DRAIN_CNT_EN
        chk(beat_cnt == 16'(n_exp_total), "beat_cnt", 64'(beat_cnt), 64'(16'(n_exp_total)));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
